dataflow_shiftreg_fifo: RTL
===========================

// Module: dataflow_shiftreg_fifo
// PURPOSE
//   Parametrised shift-register FIFO for dataflow start/stream channels between
//   HLS process modules. Generalises the fixed 1-bit/depth-2 start FIFO:
//   - any width and depth
//   - registered occupancy count
//   - almost-full flag for early producer back-pressure
//   Sits between a producer's ap_start/stream output and a consumer's input.
// PARAMETERS
//   DATA_WIDTH     default 1   payload width in bits (>=1)
//   ADDR_WIDTH     default 1   storage index width; 2**ADDR_WIDTH >= DEPTH
//   DEPTH          default 2   number of entries; 2..2**ADDR_WIDTH, need not be a power of 2
//   AF_THRESH      default 1   if_almost_full_n drops when count >= AF_THRESH; range 1..DEPTH
// PORTS
//   clk                 in   1             single clock, rising edge
//   reset               in   1             asynchronous, active-low reset
//   if_din              in   DATA_WIDTH    write data
//   if_write            in   1             write request
//   if_write_ce         in   1             write clock enable
//   if_full_n           out  1             1 = space available
//   if_almost_full_n    out  1             1 = count < AF_THRESH
//   if_dout             out  DATA_WIDTH    head-of-queue data (first-word fall-through)
//   if_read             in   1             read request
//   if_read_ce          in   1             read clock enable
//   if_empty_n          out  1             1 = data available
//   if_num_data_valid   out  ADDR_WIDTH+1  current occupancy (count)
// BEHAVIOUR
//   - Accepted write (wr_acc) = if_write & if_write_ce & if_full_n.
//     Accepted read (rd_acc)  = if_read & if_read_ce & if_empty_n.
//     Requests that are not accepted are ignored: no state change.
//   - Storage: DEPTH-entry shift register, no reset. On wr_acc every entry
//     shifts up one place, with sreg[0] <= if_din.
//   - Read index: rd_addr = count-1 when count>0, else 0.
//     if_dout = sreg[rd_addr], combinational from registers. Read latency 0:
//     the head is valid in the same cycle if_empty_n=1.
//   - Count update per clock edge:
//       wr_acc & !rd_acc  -> +1
//       rd_acc & !wr_acc  -> -1
//       both              -> unchanged (shift plus the same index pops the old head)
//       neither           -> unchanged
//   - Flags are registered and computed from next_count:
//       if_empty_n = next_count != 0
//       if_full_n  = next_count != DEPTH
//       if_almost_full_n = next_count < AF_THRESH
//     A flag change is therefore visible in the cycle after the triggering edge.
//   - Full boundary: if_write asserted while full is not accepted even if a read
//     happens in the same cycle. Only the read takes effect; count = DEPTH-1.
//   - Empty boundary: if_read asserted while empty is not accepted. A write in the
//     same cycle is accepted; count = 1.
//   - No pointer wrap: count saturates by construction at 0 and DEPTH.
//     No arithmetic overflow is possible at ADDR_WIDTH+1 bits.
//   - Reset (reset=0, asynchronous, any time including mid-transfer):
//       count = 0, if_empty_n = 0, if_full_n = 1, if_almost_full_n = 1
//       if_num_data_valid = 0
//       if_dout = sreg[0], contents unspecified
//     Storage keeps its contents but they are not readable. Normal operation
//     resumes on the first rising edge after reset deasserts.
// CONFIGURATION
//   DATAFLOW_FIFO_ERR_EN defined:
//     Adds output if_err[1:0] (reset value 2'b00), sticky until reset.
//       bit0 overflow  = set on an edge with if_write & if_write_ce & !if_full_n
//       bit1 underflow = set on an edge with if_read & if_read_ce & !if_empty_n
//     Data path is identical with or without the macro.
//   DATAFLOW_FIFO_ERR_EN undefined:
//     Port if_err is absent; overflow and underflow attempts are silently ignored.
// TESTING (DATA_WIDTH=8, ADDR_WIDTH=2, DEPTH=4, AF_THRESH=3)
//   1. Write 0xA1,0xA2,0xA3,0xA4 on consecutive cycles
//        -> count 1..4; if_almost_full_n=0 from count 3; if_full_n=0 at count 4;
//           if_dout=0xA1 throughout.
//   2. From full, 4 consecutive reads
//        -> if_dout 0xA1,0xA2,0xA3,0xA4; if_empty_n=0 and count=0 after the 4th read.
//   3. At count=2 (0xB1,0xB2), read and write 0xB3 in the same cycle
//        -> count stays 2; if_dout=0xB2, then 0xB3 on the next reads.
//   4. At full, read and write 0xC5 in the same cycle
//        -> only the read is accepted; count=3; 0xC5 never appears on if_dout.
//   5. reset=0 pulsed between edges with count=3
//        -> if_empty_n=0, if_full_n=1, count=0 immediately without a clock edge;
//           first write after release returns that data.
//   6. (ERR_EN) Read at empty, then write at full
//        -> if_err=2'b10, then 2'b11; it stays 2'b11 until reset.

Source files
------------

// File: rtl/dataflow_shiftreg_fifo_if.sv
// Handshake bundle for dataflow_shiftreg_fifo: producer write side, consumer read side and status.
// if_err exists only when DATAFLOW_FIFO_ERR_EN is defined.
interface dataflow_shiftreg_fifo_if #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_write;
    logic                  if_write_ce;
    logic                  if_full_n;
    logic                  if_almost_full_n;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  if_read;
    logic                  if_read_ce;
    logic                  if_empty_n;
    logic [ADDR_WIDTH:0]   if_num_data_valid;
`ifdef DATAFLOW_FIFO_ERR_EN
    logic [1:0]            if_err;
`endif

    modport master (
        output if_din, if_write, if_write_ce, if_read, if_read_ce,
`ifdef DATAFLOW_FIFO_ERR_EN
        input  if_err,
`endif
        input  if_full_n, if_almost_full_n, if_dout, if_empty_n, if_num_data_valid
    );

    modport slave (
        input  if_din, if_write, if_write_ce, if_read, if_read_ce,
`ifdef DATAFLOW_FIFO_ERR_EN
        output if_err,
`endif
        output if_full_n, if_almost_full_n, if_dout, if_empty_n, if_num_data_valid
    );
endinterface

// File: rtl/dataflow_shiftreg_fifo.sv
// Shift-register FIFO with first-word fall-through, registered count and almost-full flag.
// Define DATAFLOW_FIFO_ERR_EN to add sticky overflow/underflow flags on if_err.
module dataflow_shiftreg_fifo #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2,
    parameter int AF_THRESH  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    dataflow_shiftreg_fifo_if.slave fifo_if
);

    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] CNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_AF    = (ADDR_WIDTH+1)'(AF_THRESH);

    logic [DATA_WIDTH-1:0] sreg [DEPTH];
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   next_count;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  empty_n_q;
    logic                  full_n_q;
    logic                  almost_full_n_q;

    assign wr_acc = fifo_if.if_write & fifo_if.if_write_ce & full_n_q;
    assign rd_acc = fifo_if.if_read  & fifo_if.if_read_ce  & empty_n_q;

    always_comb begin
        next_count = count;
        case ({wr_acc, rd_acc})
            2'b10:   next_count = count + CNT_ONE;
            2'b01:   next_count = count - CNT_ONE;
            default: next_count = count;
        endcase
    end

    // Storage is deliberately unreset; count gates what is visible.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                sreg[i] <= sreg[i-1];
            end
            sreg[0] <= fifo_if.if_din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count           <= '0;
            empty_n_q       <= 1'b0;
            full_n_q        <= 1'b1;
            almost_full_n_q <= 1'b1;
        end else begin
            count           <= next_count;
            empty_n_q       <= (next_count != '0);
            full_n_q        <= (next_count != CNT_DEPTH);
            almost_full_n_q <= (next_count < CNT_AF);
        end
    end

    // Oldest entry sits at count-1; a simultaneous shift keeps that index pointing at the new head.
    assign rd_addr = (count == '0) ? '0 : ADDR_WIDTH'(count - CNT_ONE);

    assign fifo_if.if_dout           = sreg[rd_addr];
    assign fifo_if.if_empty_n        = empty_n_q;
    assign fifo_if.if_full_n         = full_n_q;
    assign fifo_if.if_almost_full_n  = almost_full_n_q;
    assign fifo_if.if_num_data_valid = count;

`ifdef DATAFLOW_FIFO_ERR_EN
    logic [1:0] err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 2'b00;
        end else begin
            if (fifo_if.if_write & fifo_if.if_write_ce & !full_n_q) err_q[0] <= 1'b1;
            if (fifo_if.if_read  & fifo_if.if_read_ce  & !empty_n_q) err_q[1] <= 1'b1;
        end
    end

    assign fifo_if.if_err = err_q;
`endif

endmodule
